// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the shift arbiter and its barrel shifter.
package shift_pkg;

  localparam int unsigned SHIFT_W = 32;
  localparam int unsigned NUM_W   = 8;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned STAT_W  = 16;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  // op[2:1] = shift type, op[0] = 1 for register-specified amount
  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [SHIFT_W-1:0] data;
    logic [NUM_W-1:0]   num;
    logic               cin;
  } shift_req_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Two-requester shift bus plus held response channel.
interface shift_arbiter_if;
  import shift_pkg::*;

  logic               req0_valid;
  logic               req0_ready;
  logic [OP_W-1:0]    req0_op;
  logic [SHIFT_W-1:0] req0_data;
  logic [NUM_W-1:0]   req0_num;
  logic               req0_cin;

  logic               req1_valid;
  logic               req1_ready;
  logic [OP_W-1:0]    req1_op;
  logic [SHIFT_W-1:0] req1_data;
  logic [NUM_W-1:0]   req1_num;
  logic               req1_cin;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [SHIFT_W-1:0] rsp_data;
  logic               rsp_cout;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_data, req0_num, req0_cin,
    output req0_ready,
    input  req1_valid, req1_op, req1_data, req1_num, req1_cin,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_cout,
    input  rsp_ready
  );

  // Requester / consumer side
  modport master (
    output req0_valid, req0_op, req0_data, req0_num, req0_cin,
    input  req0_ready,
    output req1_valid, req1_op, req1_data, req1_num, req1_cin,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_cout,
    output rsp_ready
  );

endinterface

// File: rtl/shift_arbiter_core.sv
// barrel_shift_core: combinational ARM shifter (LSL/LSR/ASR/ROR/RRX, imm vs reg amount).
module barrel_shift_core
  import shift_pkg::*;
(
  input  shift_req_t         i_req,
  output logic [SHIFT_W-1:0] o_out,
  output logic               o_cout
);

  shift_type_e w_type;
  logic        w_is_reg;
  logic [4:0]  w_n5;
  logic [4:0]  w_lsl_idx;

  assign w_type    = shift_type_e'(i_req.op[2:1]);
  assign w_is_reg  = i_req.op[0];
  assign w_n5      = i_req.num[4:0];
  // carry bit for LSL by 1..31 is data[32-n]
  assign w_lsl_idx = 5'(6'd32 - {1'b0, w_n5});

  // Shift result and carry-out; zero amount forms handled first
  always_comb begin
    o_out  = i_req.data;
    o_cout = i_req.cin;
    if (i_req.num == '0) begin
      if (!w_is_reg) begin
        case (w_type)
          LSR: begin
            o_out  = '0;
            o_cout = i_req.data[31];
          end
          ASR: begin
            o_out  = {SHIFT_W{i_req.data[31]}};
            o_cout = i_req.data[31];
          end
          ROR: begin
            o_out  = {i_req.cin, i_req.data[31:1]};
            o_cout = i_req.data[0];
          end
          default: ;
        endcase
      end
    end else begin
      case (w_type)
        LSL: begin
          if (i_req.num < 8'd32) begin
            o_out  = i_req.data << w_n5;
            o_cout = i_req.data[w_lsl_idx];
          end else if (i_req.num == 8'd32) begin
            o_out  = '0;
            o_cout = i_req.data[0];
          end else begin
            o_out  = '0;
            o_cout = 1'b0;
          end
        end
        LSR: begin
          if (i_req.num < 8'd32) begin
            o_out  = i_req.data >> w_n5;
            o_cout = i_req.data[w_n5 - 5'd1];
          end else if (i_req.num == 8'd32) begin
            o_out  = '0;
            o_cout = i_req.data[31];
          end else begin
            o_out  = '0;
            o_cout = 1'b0;
          end
        end
        ASR: begin
          if (i_req.num < 8'd32) begin
            o_out  = $unsigned($signed(i_req.data) >>> w_n5);
            o_cout = i_req.data[w_n5 - 5'd1];
          end else begin
            o_out  = {SHIFT_W{i_req.data[31]}};
            o_cout = i_req.data[31];
          end
        end
        default: begin
          if (w_n5 == '0) begin
            o_out  = i_req.data;
            o_cout = i_req.data[31];
          end else begin
            o_out  = (i_req.data >> w_n5) | (i_req.data << (6'd32 - {1'b0, w_n5}));
            o_cout = o_out[31];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin share of one barrel shifter between two requesters,
// with a registered, held response. Optional macro SHIFT_ARB_STATS_EN adds
// saturating grant/stall counters.
module shift_arbiter
  import shift_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  shift_arbiter_if.slave      bus
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat_grant0,
  output logic [STAT_W-1:0]   stat_grant1,
  output logic [STAT_W-1:0]   stat_stall
`endif
);

  arb_state_e         r_state;
  arb_state_e         w_nxt_state;
  logic               r_ptr;
  logic               r_rsp_valid;
  logic               r_rsp_id;
  logic [SHIFT_W-1:0] r_rsp_data;
  logic               r_rsp_cout;

  logic               w_can_accept;
  logic               w_gnt0;
  logic               w_gnt1;
  shift_req_t         w_req0;
  shift_req_t         w_req1;
  shift_req_t         w_sel;
  logic [SHIFT_W-1:0] w_shift_out;
  logic               w_shift_cout;

  assign w_req0 = '{op: bus.req0_op, data: bus.req0_data, num: bus.req0_num, cin: bus.req0_cin};
  assign w_req1 = '{op: bus.req1_op, data: bus.req1_data, num: bus.req1_num, cin: bus.req1_cin};

  // no grant while reset is held, even though the FSM already sits in IDLE
  assign w_can_accept = !rst && ((r_state == ST_IDLE) || bus.rsp_ready);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt_state;
  end

  // Next state and grant decode
  always_comb begin
    w_nxt_state = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    if (w_can_accept) begin
      if (bus.req0_valid && (!bus.req1_valid || !r_ptr)) w_gnt0 = 1'b1;
      else if (bus.req1_valid)                           w_gnt1 = 1'b1;
    end
    if (w_gnt0 || w_gnt1)                           w_nxt_state = ST_HOLD;
    else if ((r_state == ST_HOLD) && bus.rsp_ready) w_nxt_state = ST_IDLE;
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  assign w_sel = w_gnt1 ? w_req1 : w_req0;

  barrel_shift_core u_core (
    .i_req  (w_sel),
    .o_out  (w_shift_out),
    .o_cout (w_shift_cout)
  );

  // Round-robin pointer: after any grant, favour the other requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_ptr <= 1'b0;
    else if (w_gnt0) r_ptr <= 1'b1;
    else if (w_gnt1) r_ptr <= 1'b0;
  end

  // Response register: load on grant, drop when consumed with nothing new
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_cout  <= 1'b0;
    end else if (w_gnt0 || w_gnt1) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gnt1;
      r_rsp_data  <= w_shift_out;
      r_rsp_cout  <= w_shift_cout;
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_cout  = r_rsp_cout;

`ifdef SHIFT_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_grant0;
  logic [STAT_W-1:0] r_stat_grant1;
  logic [STAT_W-1:0] r_stat_stall;

  // Saturating grant and stall counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_grant0 <= '0;
      r_stat_grant1 <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_gnt0 && (r_stat_grant0 != '1)) r_stat_grant0 <= r_stat_grant0 + STAT_W'(1);
      if (w_gnt1 && (r_stat_grant1 != '1)) r_stat_grant1 <= r_stat_grant1 + STAT_W'(1);
      if (r_rsp_valid && !bus.rsp_ready && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + STAT_W'(1);
    end
  end

  assign stat_grant0 = r_stat_grant0;
  assign stat_grant1 = r_stat_grant1;
  assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_shift_arbiter;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  shift_arbiter_if bus ();

`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] st_g0, st_g1, st_st;
`endif

  shift_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .stat_grant0 (st_g0),
    .stat_grant1 (st_g1),
    .stat_stall  (st_st)
`endif
  );

  always #5 clk = ~clk;

  // reference model state
  logic        m_valid, m_id, m_cout, m_ptr;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ARM shifter, one bit at a time; returns {cout, out}
  function automatic logic [32:0] ref_shift(input logic [2:0] op, input logic [31:0] d_in,
                                            input logic [7:0] n, input logic c_in);
    logic [31:0] d;
    logic        c;
    int          cnt;
    int          r;
    d = d_in;
    c = c_in;
    if (n == 0) begin
      if (op[0]) return {c, d};
      case (op[2:1])
        2'b00: return {c, d};
        2'b11: return {d[0], c, d[31:1]};
        default: cnt = 32;
      endcase
    end else begin
      cnt = int'(n);
    end
    case (op[2:1])
      2'b00: for (int i = 0; i < cnt; i++) begin c = d[31]; d = d << 1; end
      2'b01: for (int i = 0; i < cnt; i++) begin c = d[0]; d = d >> 1; end
      2'b10: for (int i = 0; i < cnt; i++) begin c = d[0]; d = {d[31], d[31:1]}; end
      default: begin
        r = cnt % 32;
        if (r == 0) c = d[31];
        else begin
          for (int i = 0; i < r; i++) d = {d[0], d[31:1]};
          c = d[31];
        end
      end
    endcase
    return {c, d};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_id = 1'b0; m_data = '0; m_cout = 1'b0; m_ptr = 1'b0;
  endtask

  // One cycle: entered and left at a negedge
  task automatic step(input logic v0, input shift_req_t q0, input logic v1,
                      input shift_req_t q1, input logic rr);
    logic        can, g0, g1;
    logic [32:0] res;
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
    chk("rsp_cout_known", 64'(!$isunknown(bus.rsp_cout)), 64'd1);
    if (m_valid) begin
      chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
      chk("rsp_data", 64'(bus.rsp_data), 64'(m_data));
      chk("rsp_cout", 64'(bus.rsp_cout), 64'(m_cout));
    end
    bus.req0_valid = v0; bus.req0_op = q0.op; bus.req0_data = q0.data;
    bus.req0_num = q0.num; bus.req0_cin = q0.cin;
    bus.req1_valid = v1; bus.req1_op = q1.op; bus.req1_data = q1.data;
    bus.req1_num = q1.num; bus.req1_cin = q1.cin;
    bus.rsp_ready = rr;
    #1;
    can = !m_valid || rr;
    g0 = 1'b0; g1 = 1'b0;
    if (can) begin
      if (v0 && v1) begin g0 = !m_ptr; g1 = m_ptr; end
      else if (v0) g0 = 1'b1;
      else if (v1) g1 = 1'b1;
    end
    chk("req0_ready", 64'(bus.req0_ready), 64'(g0));
    chk("req1_ready", 64'(bus.req1_ready), 64'(g1));
    if (g0 || g1) begin
      res = g1 ? ref_shift(q1.op, q1.data, q1.num, q1.cin)
               : ref_shift(q0.op, q0.data, q0.num, q0.cin);
      m_valid = 1'b1; m_id = g1; m_data = res[31:0]; m_cout = res[32];
      m_ptr = g0;
    end else if (m_valid && rr) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] pick_num();
    case ($urandom_range(0, 6))
      0: return 8'd0;
      1: return 8'd1;
      2: return 8'd31;
      3: return 8'd32;
      4: return 8'd33;
      5: return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic shift_req_t rnd_req();
    shift_req_t q;
    q.op   = 3'($urandom_range(0, 7));
    q.data = $urandom;
    q.num  = pick_num();
    q.cin  = 1'($urandom_range(0, 1));
    return q;
  endfunction

  shift_req_t q_a, q_b, q_z;
  logic [31:0] held_data;
  logic        held_cout;

  initial begin
    q_z = '{op: 3'b000, data: 32'h0, num: 8'h0, cin: 1'b0};
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_data = '0; bus.req0_num = '0; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_data = '0; bus.req1_num = '0; bus.req1_cin = 1'b0;
    bus.rsp_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_rsp_cout", 64'(bus.rsp_cout), 64'd0);
    chk("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
    chk("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
    rst = 1'b0;

    // LSL #1 on 0x80000001
    q_a = '{op: 3'b000, data: 32'h8000_0001, num: 8'd1, cin: 1'b0};
    step(1'b1, q_a, 1'b0, q_z, 1'b1);
    chk("t1_id", 64'(bus.rsp_id), 64'd0);
    chk("t1_data", 64'(bus.rsp_data), 64'h0000_0002);
    chk("t1_cout", 64'(bus.rsp_cout), 64'd1);
    step(1'b0, q_z, 1'b0, q_z, 1'b1);

    // RRX
    q_a = '{op: 3'b110, data: 32'h0000_0003, num: 8'd0, cin: 1'b1};
    step(1'b1, q_a, 1'b0, q_z, 1'b1);
    chk("t3_data", 64'(bus.rsp_data), 64'h8000_0001);
    chk("t3_cout", 64'(bus.rsp_cout), 64'd1);

    // ASR / LSR register amount 40
    q_a = '{op: 3'b101, data: 32'h8000_0000, num: 8'd40, cin: 1'b0};
    step(1'b0, q_z, 1'b1, q_a, 1'b1);
    chk("t4_asr_data", 64'(bus.rsp_data), 64'hFFFF_FFFF);
    chk("t4_asr_cout", 64'(bus.rsp_cout), 64'd1);
    q_a.op = 3'b011;
    step(1'b0, q_z, 1'b1, q_a, 1'b1);
    chk("t4_lsr_data", 64'(bus.rsp_data), 64'h0);
    chk("t4_lsr_cout", 64'(bus.rsp_cout), 64'd0);
    step(1'b0, q_z, 1'b0, q_z, 1'b1);

    // back-pressure with req1 pending
    q_a = '{op: 3'b010, data: 32'hF000_000F, num: 8'd4, cin: 1'b0};
    q_b = '{op: 3'b000, data: 32'h0000_00FF, num: 8'd8, cin: 1'b0};
    step(1'b1, q_a, 1'b0, q_z, 1'b0);
    held_data = bus.rsp_data;
    held_cout = bus.rsp_cout;
    chk("t5_first_data", 64'(held_data), 64'h0F00_0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, q_z, 1'b1, q_b, 1'b0);
      chk("t5_hold_data", 64'(bus.rsp_data), 64'(held_data));
      chk("t5_hold_cout", 64'(bus.rsp_cout), 64'(held_cout));
    end
    step(1'b0, q_z, 1'b1, q_b, 1'b1);
    chk("t5_id", 64'(bus.rsp_id), 64'd1);
    chk("t5_data", 64'(bus.rsp_data), 64'h0000_FF00);
    step(1'b0, q_z, 1'b0, q_z, 1'b1);

    // async reset, then both valid every cycle: 0,1,0,1
    q_a = rnd_req();
    step(1'b1, q_a, 1'b0, q_z, 1'b0);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t6_req0_ready", 64'(bus.req0_ready), 64'd0);
    chk("t6_req1_ready", 64'(bus.req1_ready), 64'd0);
    model_reset();
    @(negedge clk);
    chk("t6_hold_req0_ready", 64'(bus.req0_ready), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q_a = rnd_req();
      q_b = rnd_req();
      step(1'b1, q_a, 1'b1, q_b, 1'b1);
      chk("t2_alt_id", 64'(bus.rsp_id), 64'(i % 2));
      chk("t2_alt_valid", 64'(bus.rsp_valid), 64'd1);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      q_a = rnd_req();
      q_b = rnd_req();
      step(1'($urandom_range(0, 3) != 0), q_a, 1'($urandom_range(0, 3) != 0), q_b,
           1'($urandom_range(0, 3) != 0));
    end
    step(1'b0, q_z, 1'b0, q_z, 1'b1);
    step(1'b0, q_z, 1'b0, q_z, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
